// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: ALU opcodes, forwarding select encoding,
// register-number width and the execute-stage control bundle.
package riscv_pkg;

  localparam int REG_NUM_W = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_EQ  = 3'b001;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [2:0] alu_ctrl;
  } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: picks the youngest in-flight producer of rs_e,
// never forwarding x0.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = REG_NUM_W
) (
  input  logic [REG_AW-1:0] rs_e,
  input  logic [WIDTH-1:0]  reg_val,
  input  logic              exmem_we,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [WIDTH-1:0]  exmem_result,
  input  logic              memwb_we,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [WIDTH-1:0]  memwb_result,
  output logic [WIDTH-1:0]  operand,
  output fwd_sel_t          sel
);

  always_comb begin
    sel     = FWD_REG;
    operand = reg_val;
    // EX/MEM is younger than MEM/WB, so it is checked first
    if (exmem_we && (exmem_rd != '0) && (exmem_rd == rs_e)) begin
      sel     = FWD_MEM;
      operand = exmem_result;
    end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == rs_e)) begin
      sel     = FWD_WB;
      operand = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, saturating bubble
// counter and EX/MEM, MEM/WB operand forwarding into the ALU.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = REG_NUM_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidD,
  input  logic [WIDTH-1:0]  RD1D,
  input  logic [WIDTH-1:0]  RD2D,
  input  logic [WIDTH-1:0]  ImmExtD,
  input  logic [WIDTH-1:0]  PCD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic [2:0]        ALUctrlD,
  input  logic              ALUSrcD,
  input  logic              RegWriteD,
  input  logic              MemReadD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              Flush,
  input  logic              Hold,
  input  logic              ExMemRegWrite,
  input  logic [REG_AW-1:0] ExMemRd,
  input  logic [WIDTH-1:0]  ExMemResult,
  input  logic              MemWbRegWrite,
  input  logic [REG_AW-1:0] MemWbRd,
  input  logic [WIDTH-1:0]  MemWbResult,
  output logic [WIDTH-1:0]  SrcA,
  output logic [WIDTH-1:0]  SrcB,
  output logic [2:0]        ALUctrlE,
  output logic [WIDTH-1:0]  WriteDataE,
  output logic [WIDTH-1:0]  PCE,
  output logic [WIDTH-1:0]  ImmExtE,
  output logic [REG_AW-1:0] RdE,
  output logic              ValidE,
  output logic              RegWriteE,
  output logic              MemReadE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              StallD,
  output logic [CNT_W-1:0]  BubbleCount,
  output fwd_sel_t          FwdSelA,
  output fwd_sel_t          FwdSelB
);

  ex_ctrl_t          ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_use;
  logic [WIDTH-1:0]  fwd_a, fwd_b;

  // rs2 only matters when it is an ALU operand or store data
  assign load_use = ValidD & ctrl_q.valid & ctrl_q.mem_read & (rd_q != '0) &
                    ((rd_q == Rs1D) | ((rd_q == Rs2D) & (~ALUSrcD | MemWriteD)));
  assign StallD   = load_use | Hold;

  always_comb begin
    ctrl_d = ctrl_q;
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    if (Flush) begin
      ctrl_d = '0;
    end else if (Hold) begin
      ctrl_d = ctrl_q;
    end else if (load_use) begin
      ctrl_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ctrl_d.valid     = ValidD;
      ctrl_d.reg_write = RegWriteD & ValidD;
      ctrl_d.mem_read  = MemReadD & ValidD;
      ctrl_d.mem_write = MemWriteD & ValidD;
      ctrl_d.branch    = BranchD & ValidD;
      ctrl_d.alu_src   = ALUSrcD & ValidD;
      ctrl_d.alu_ctrl  = ValidD ? ALUctrlD : ALU_ADD;
      rd1_d = RD1D;
      rd2_d = RD2D;
      imm_d = ImmExtD;
      pc_d  = PCD;
      rs1_d = Rs1D;
      rs2_d = Rs2D;
      rd_d  = RdD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      pc_q   <= pc_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_a (
    .rs_e(rs1_q), .reg_val(rd1_q),
    .exmem_we(ExMemRegWrite), .exmem_rd(ExMemRd), .exmem_result(ExMemResult),
    .memwb_we(MemWbRegWrite), .memwb_rd(MemWbRd), .memwb_result(MemWbResult),
    .operand(fwd_a), .sel(FwdSelA)
  );

  fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_b (
    .rs_e(rs2_q), .reg_val(rd2_q),
    .exmem_we(ExMemRegWrite), .exmem_rd(ExMemRd), .exmem_result(ExMemResult),
    .memwb_we(MemWbRegWrite), .memwb_rd(MemWbRd), .memwb_result(MemWbResult),
    .operand(fwd_b), .sel(FwdSelB)
  );

  assign SrcA        = fwd_a;
  assign SrcB        = ctrl_q.alu_src ? imm_q : fwd_b;
  assign WriteDataE  = fwd_b;
  assign ALUctrlE    = ctrl_q.alu_ctrl;
  assign PCE         = pc_q;
  assign ImmExtE     = imm_q;
  assign RdE         = rd_q;
  assign ValidE      = ctrl_q.valid;
  assign RegWriteE   = ctrl_q.reg_write;
  assign MemReadE    = ctrl_q.mem_read;
  assign MemWriteE   = ctrl_q.mem_write;
  assign BranchE     = ctrl_q.branch;
  assign BubbleCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized checks of id_ex_stage against an instruction-slot
// reference model; a narrow bubble counter makes saturation reachable.
module tb_id_ex_stage;
  import riscv_pkg::*;

  localparam int W    = 32;
  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ValidD, ALUSrcD, RegWriteD, MemReadD, MemWriteD, BranchD;
  logic [W-1:0]  RD1D, RD2D, ImmExtD, PCD, ExMemResult, MemWbResult;
  logic [AW-1:0] Rs1D, Rs2D, RdD, ExMemRd, MemWbRd;
  logic [2:0]    ALUctrlD;
  logic          Flush, Hold, ExMemRegWrite, MemWbRegWrite;
  logic [W-1:0]  SrcA, SrcB, WriteDataE, PCE, ImmExtE;
  logic [2:0]    ALUctrlE;
  logic [AW-1:0] RdE;
  logic          ValidE, RegWriteE, MemReadE, MemWriteE, BranchE, StallD;
  logic [CW-1:0] BubbleCount;
  fwd_sel_t      FwdSelA, FwdSelB;

  id_ex_stage #(.WIDTH(W), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ValidD(ValidD), .RD1D(RD1D), .RD2D(RD2D),
    .ImmExtD(ImmExtD), .PCD(PCD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ALUctrlD(ALUctrlD), .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD),
    .MemReadD(MemReadD), .MemWriteD(MemWriteD), .BranchD(BranchD),
    .Flush(Flush), .Hold(Hold), .ExMemRegWrite(ExMemRegWrite),
    .ExMemRd(ExMemRd), .ExMemResult(ExMemResult), .MemWbRegWrite(MemWbRegWrite),
    .MemWbRd(MemWbRd), .MemWbResult(MemWbResult), .SrcA(SrcA), .SrcB(SrcB),
    .ALUctrlE(ALUctrlE), .WriteDataE(WriteDataE), .PCE(PCE), .ImmExtE(ImmExtE),
    .RdE(RdE), .ValidE(ValidE), .RegWriteE(RegWriteE), .MemReadE(MemReadE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .StallD(StallD),
    .BubbleCount(BubbleCount), .FwdSelA(FwdSelA), .FwdSelB(FwdSelB)
  );

  int checks = 0;
  int errors = 0;

  // The instruction currently sitting in execute, as the model sees it
  typedef struct {
    bit        valid, rw, mr, mw, br, alusrc;
    bit [2:0]  aluctrl;
    bit [31:0] rd1, rd2, imm, pc;
    bit [4:0]  rs1, rs2, rd;
  } slot_t;
  slot_t m;
  int    cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_loaduse();
    return ValidD && m.valid && m.mr && (m.rd != 0) &&
           ((m.rd == Rs1D) || ((m.rd == Rs2D) && (!ALUSrcD || MemWriteD)));
  endfunction

  function automatic bit [31:0] m_fwd_val(input bit [4:0] rs, input bit [31:0] rv);
    if (ExMemRegWrite && ExMemRd != 0 && ExMemRd == rs) return ExMemResult;
    if (MemWbRegWrite && MemWbRd != 0 && MemWbRd == rs) return MemWbResult;
    return rv;
  endfunction

  function automatic fwd_sel_t m_fwd_sel(input bit [4:0] rs);
    if (ExMemRegWrite && ExMemRd != 0 && ExMemRd == rs) return FWD_MEM;
    if (MemWbRegWrite && MemWbRd != 0 && MemWbRd == rs) return FWD_WB;
    return FWD_REG;
  endfunction

  task automatic model_reset();
    m   = '{default: 0};
    cnt = 0;
  endtask

  task automatic model_step();
    bit lu;
    lu = m_loaduse();
    if (rst) model_reset();
    else if (Flush) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.br = 0; m.alusrc = 0; m.aluctrl = 0;
    end else if (Hold) begin
      // instruction stays put
    end else if (lu) begin
      m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.br = 0; m.alusrc = 0; m.aluctrl = 0;
      if (cnt < CMAX) cnt++;
    end else begin
      m.valid = ValidD;  m.rw = RegWriteD && ValidD; m.mr = MemReadD && ValidD;
      m.mw = MemWriteD && ValidD; m.br = BranchD && ValidD;
      m.alusrc = ALUSrcD && ValidD; m.aluctrl = ValidD ? ALUctrlD : 3'b000;
      m.rd1 = RD1D; m.rd2 = RD2D; m.imm = ImmExtD; m.pc = PCD;
      m.rs1 = Rs1D; m.rs2 = Rs2D; m.rd = RdD;
    end
  endtask

  task automatic check_now();
    bit [31:0] a, b;
    #1;
    chk("StallD", StallD, 32'(m_loaduse() || Hold));
    chk("ValidE", ValidE, 32'(m.valid));
    chk("RegWriteE", RegWriteE, 32'(m.rw));
    chk("MemReadE", MemReadE, 32'(m.mr));
    chk("MemWriteE", MemWriteE, 32'(m.mw));
    chk("BranchE", BranchE, 32'(m.br));
    chk("ALUctrlE", ALUctrlE, 32'(m.aluctrl));
    chk("BubbleCount", BubbleCount, 32'(cnt));
    if (m.valid) begin
      a = m_fwd_val(m.rs1, m.rd1);
      b = m_fwd_val(m.rs2, m.rd2);
      chk("SrcA", SrcA, a);
      chk("SrcB", SrcB, m.alusrc ? m.imm : b);
      chk("WriteDataE", WriteDataE, b);
      chk("PCE", PCE, m.pc);
      chk("ImmExtE", ImmExtE, m.imm);
      chk("RdE", RdE, 32'(m.rd));
      chk("FwdSelA", 32'(FwdSelA), 32'(m_fwd_sel(m.rs1)));
      chk("FwdSelB", 32'(FwdSelB), 32'(m_fwd_sel(m.rs2)));
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    ValidD = 0; ALUSrcD = 0; RegWriteD = 0; MemReadD = 0; MemWriteD = 0; BranchD = 0;
    RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0; Rs1D = 0; Rs2D = 0; RdD = 0; ALUctrlD = 0;
    Flush = 0; Hold = 0; ExMemRegWrite = 0; ExMemRd = 0; ExMemResult = 0;
    MemWbRegWrite = 0; MemWbRd = 0; MemWbResult = 0;
  endtask

  task automatic set_lw(input bit [4:0] rd, input bit [4:0] rs1);
    idle(); ValidD = 1; MemReadD = 1; RegWriteD = 1; RdD = rd; Rs1D = rs1;
  endtask

  task automatic set_add(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                         input bit [31:0] v1, input bit [31:0] v2);
    idle(); ValidD = 1; RegWriteD = 1; RdD = rd; Rs1D = rs1; Rs2D = rs2; RD1D = v1; RD2D = v2;
  endtask

  task automatic randomize_inputs();
    ValidD = 1'($urandom); ALUSrcD = 1'($urandom); RegWriteD = 1'($urandom);
    MemReadD = ($urandom_range(0, 2) == 0); MemWriteD = ($urandom_range(0, 3) == 0);
    BranchD = ($urandom_range(0, 3) == 0); ALUctrlD = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom; PCD = $urandom;
    Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7)); RdD = 5'($urandom_range(0, 7));
    Flush = ($urandom_range(0, 9) == 0); Hold = ($urandom_range(0, 9) == 0);
    ExMemRegWrite = 1'($urandom); ExMemRd = 5'($urandom_range(0, 7)); ExMemResult = $urandom;
    MemWbRegWrite = 1'($urandom); MemWbRd = 5'($urandom_range(0, 7)); MemWbResult = $urandom;
  endtask

  initial begin
    int cnt0;
    idle();
    rst = 1;
    model_reset();
    @(negedge clk);
    check_now();
    chk("reset_SrcA", SrcA, 32'h0);
    chk("reset_SrcB", SrcB, 32'h0);
    @(negedge clk);
    rst = 0;

    // load-use: lw x6 then add x7, x6, x1
    set_lw(5'd6, 5'd2);
    check_now(); adv();
    set_add(5'd7, 5'd6, 5'd1, 32'hDEAD, 32'h11);
    check_now(); chk("lu_stall", StallD, 1);
    adv();
    check_now();
    chk("lu_bubble_valid", ValidE, 0);
    chk("lu_bubble_rw", RegWriteE, 0);
    chk("lu_count", BubbleCount, 1);
    chk("lu_stall_clear", StallD, 0);
    adv();
    idle(); MemWbRegWrite = 1; MemWbRd = 6; MemWbResult = 32'h66;
    check_now();
    chk("lu_fwd_srca", SrcA, 32'h66);
    chk("lu_add_valid", ValidE, 1);

    // double forward priority
    set_add(5'd8, 5'd5, 5'd0, 32'h5555, 32'h0);
    adv();
    idle();
    ExMemRegWrite = 1; ExMemRd = 5; ExMemResult = 32'hAAAA;
    MemWbRegWrite = 1; MemWbRd = 5; MemWbResult = 32'hBBBB;
    check_now(); chk("dfwd_mem", SrcA, 32'hAAAA);
    ExMemRegWrite = 0;
    check_now(); chk("dfwd_wb", SrcA, 32'hBBBB);
    ExMemRegWrite = 1; ExMemRd = 0; MemWbRd = 0;
    check_now(); chk("dfwd_x0", SrcA, 32'h5555);

    // flush wins over a simultaneous load-use
    set_lw(5'd6, 5'd0);
    adv();
    cnt0 = cnt;
    set_add(5'd7, 5'd6, 5'd6, 32'h1, 32'h2); Flush = 1;
    check_now(); chk("flush_stall", StallD, 1);
    adv();
    idle();
    check_now();
    chk("flush_valid", ValidE, 0);
    chk("flush_count", BubbleCount, 32'(cnt0));

    // hold for three cycles
    set_add(5'd9, 5'd3, 5'd4, 32'hC0FFEE, 32'h44); PCD = 32'h100;
    adv();
    set_add(5'd10, 5'd1, 5'd2, 32'h1, 32'h2); PCD = 32'h200; Hold = 1;
    for (int i = 0; i < 3; i++) begin
      check_now();
      chk("hold_stall", StallD, 1);
      chk("hold_pce", PCE, 32'h100);
      chk("hold_srca", SrcA, 32'hC0FFEE);
      adv();
    end
    Hold = 0;
    check_now();
    chk("hold_release_pce", PCE, 32'h100);
    adv();
    check_now(); chk("after_hold_pce", PCE, 32'h200);

    // immediate operand with forwarded store data
    idle(); ValidD = 1; ALUSrcD = 1; MemWriteD = 1; ImmExtD = 32'hFFFFFFFC;
    Rs1D = 1; Rs2D = 3; RD1D = 32'h10; RD2D = 32'h3333;
    adv();
    idle(); ExMemRegWrite = 1; ExMemRd = 3; ExMemResult = 32'h7777;
    check_now();
    chk("imm_srcb", SrcB, 32'hFFFFFFFC);
    chk("imm_wdata", WriteDataE, 32'h7777);

    // randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      randomize_inputs();
      if (rst) rst = ($urandom_range(0, 1) == 0);
      else if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1;
        model_reset();
      end
      check_now();
      adv();
    end
    rst = 0;
    adv();

    // reset mid-stream while a valid instruction is presented
    set_add(5'd2, 5'd1, 5'd0, 32'h1234, 32'h0);
    #2 rst = 1;
    model_reset();
    check_now();
    chk("rst_valid", ValidE, 0);
    chk("rst_srca", SrcA, 0);
    chk("rst_count", BubbleCount, 0);
    adv();
    check_now();
    chk("rst_hold_srca", SrcA, 0);
    rst = 0;
    adv();
    check_now();
    chk("rst_release_srca", SrcA, 32'h1234);

    // drive the bubble counter into saturation
    for (int i = 0; i < CMAX + 5; i++) begin
      set_lw(5'd6, 5'd0);
      check_now(); adv();
      set_add(5'd7, 5'd6, 5'd0, 32'h0, 32'h0);
      check_now(); adv();
      check_now(); adv();
    end
    idle();
    check_now();
    chk("sat_count", BubbleCount, 32'(CMAX));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
